val2_shift_sequencer: RTL and testbench

- Multi-cycle iterative replacement for the single-cycle EXE-stage Val2 barrel shifter.
- Latches the operand-2 request (mem offset, rotated immediate or shifted Rm) and shifts STEP bit positions per clock under an FSM.
- Returns val2 with a done pulse; busy drives the hazard unit to stall ID/EXE.
- Trades latency for a shorter critical path in the EXE stage.

---
 rtl/val2_shift_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_val2_shift_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/val2_shift_sequencer.sv
// rtl/val2_shift_sequencer.sv - multi-cycle iterative Val2 shifter for the EXE stage
//
// Purpose:
//   Replaces the single-cycle Val2 barrel shifter with a small FSM. It latches
//   the operand-2 request and applies STEP single-bit shift steps per clock
//   until the requested amount has been used up. It then presents val2 with a
//   one-cycle done pulse. busy lets the hazard unit stall ID/EXE.
//
// Parameters:
//   STEP           bit positions applied per clock in SHIFT (1, 2, 4 or 8)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   start          request strobe, accepted in IDLE or DONE, ignored in SHIFT
//   mem_inst       LDR/STR form: val2 = sign-extended 12-bit offset (wins over imm)
//   imm            immediate form: imm8 rotated right by 2*rotate
//   val_rm         Rm register value
//   shift_operand  instruction bits [11:0]
//   val2           result, valid with done, held until the next result
//   done           one-cycle completion pulse
//   busy           high while shifting
//   shift_carry    (only with VAL2_SHIFT_CARRY_EN) last bit shifted out, held like val2
//
// Build option:
//   VAL2_SHIFT_CARRY_EN  adds the shift_carry output and its logic.

module val2_shift_sequencer #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_inst,
  input  logic        imm,
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  output logic [31:0] val2,
  output logic        done,
  output logic        busy
`ifdef VAL2_SHIFT_CARRY_EN
  ,
  output logic        shift_carry
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t      state, state_n;
  logic [31:0] acc, acc_n;
  logic [4:0]  cnt, cnt_n;
  logic [1:0]  op, op_n;
  logic [31:0] val2_q, val2_n;

  // decoded request, meaningful only on the accepting edge
  logic [31:0] lat_acc;
  logic [4:0]  lat_n;
  logic [1:0]  lat_op;

  // one clock of iterative shifting
  logic [4:0]  k;
  logic [4:0]  cnt_left;
  logic [31:0] stp_acc;

  logic accept;

`ifdef VAL2_SHIFT_CARRY_EN
  logic carry_q, carry_n;
  logic stp_out;
`endif

  // start is ignored while shifting; DONE accepts, giving back-to-back issue
  assign accept = start && (state != SHIFT);

  // Operand-2 decode. mem_inst has priority over imm.
  always_comb begin
    lat_acc = val_rm;
    lat_n   = shift_operand[11:7];
    lat_op  = shift_operand[6:5];
    if (mem_inst) begin
      lat_acc = {{20{shift_operand[11]}}, shift_operand};
      lat_n   = 5'd0;
      lat_op  = OP_LSL;
    end else if (imm) begin
      lat_acc = {24'b0, shift_operand[7:0]};
      lat_n   = {shift_operand[11:8], 1'b0};
      lat_op  = OP_ROR;
    end
  end

  // Apply min(STEP, cnt) single-bit steps to acc. Each step is a plain
  // one-position shift, so amount 0 is never special-cased.
  always_comb begin
    k        = (cnt < STEP5) ? cnt : STEP5;
    cnt_left = cnt - k;
    stp_acc  = acc;
`ifdef VAL2_SHIFT_CARRY_EN
    stp_out  = 1'b0;
`endif
    for (int i = 0; i < STEP; i++) begin
      if (5'(i) < k) begin
        unique case (op)
          OP_LSL: begin
`ifdef VAL2_SHIFT_CARRY_EN
            stp_out = stp_acc[31];
`endif
            stp_acc = {stp_acc[30:0], 1'b0};
          end
          OP_LSR: begin
`ifdef VAL2_SHIFT_CARRY_EN
            stp_out = stp_acc[0];
`endif
            stp_acc = {1'b0, stp_acc[31:1]};
          end
          OP_ASR: begin
`ifdef VAL2_SHIFT_CARRY_EN
            stp_out = stp_acc[0];
`endif
            stp_acc = {stp_acc[31], stp_acc[31:1]};
          end
          default: begin
            // ROR: the bit rotated into bit31 is also the carry
`ifdef VAL2_SHIFT_CARRY_EN
            stp_out = stp_acc[0];
`endif
            stp_acc = {stp_acc[0], stp_acc[31:1]};
          end
        endcase
      end
    end
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    op_n    = op;
    val2_n  = val2_q;
`ifdef VAL2_SHIFT_CARRY_EN
    carry_n = carry_q;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          acc_n = lat_acc;
          cnt_n = lat_n;
          op_n  = lat_op;
          if (lat_n == 5'd0) begin
            // zero amount: result is available on the very next cycle
            state_n = DONE;
            val2_n  = lat_acc;
`ifdef VAL2_SHIFT_CARRY_EN
            carry_n = 1'b0;
`endif
          end else begin
            state_n = SHIFT;
          end
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        acc_n = stp_acc;
        cnt_n = cnt_left;
        if (cnt_left == 5'd0) begin
          state_n = DONE;
          val2_n  = stp_acc;
`ifdef VAL2_SHIFT_CARRY_EN
          carry_n = stp_out;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= 32'd0;
      cnt    <= 5'd0;
      op     <= OP_LSL;
      val2_q <= 32'd0;
`ifdef VAL2_SHIFT_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      acc    <= acc_n;
      cnt    <= cnt_n;
      op     <= op_n;
      val2_q <= val2_n;
`ifdef VAL2_SHIFT_CARRY_EN
      carry_q <= carry_n;
`endif
    end
  end

  // Both flags decode the state register directly, so they are glitch-free
  // and mutually exclusive.
  assign done = (state == DONE);
  assign busy = (state == SHIFT);
  assign val2 = val2_q;
`ifdef VAL2_SHIFT_CARRY_EN
  assign shift_carry = carry_q;
`endif

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// tb/tb_val2_shift_sequencer.sv - randomized self-checking bench for val2_shift_sequencer
//
// Purpose:
//   Drives two instances (STEP=1 and STEP=4) from the same inputs. Each
//   result, latency and busy count is compared with an arithmetic reference
//   model.
// Ports: none (top-level bench).

module tb_val2_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_inst = 1'b0;
  logic        imm = 1'b0;
  logic [31:0] val_rm = 32'd0;
  logic [11:0] shift_operand = 12'd0;

  logic [31:0] val2_a, val2_b;
  logic        done_a, done_b, busy_a, busy_b;
`ifdef VAL2_SHIFT_CARRY_EN
  logic        carry_a, carry_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  val2_shift_sequencer #(.STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mem_inst(mem_inst), .imm(imm),
    .val_rm(val_rm), .shift_operand(shift_operand),
    .val2(val2_a), .done(done_a), .busy(busy_a)
`ifdef VAL2_SHIFT_CARRY_EN
    , .shift_carry(carry_a)
`endif
  );

  val2_shift_sequencer #(.STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .mem_inst(mem_inst), .imm(imm),
    .val_rm(val_rm), .shift_operand(shift_operand),
    .val2(val2_b), .done(done_b), .busy(busy_b)
`ifdef VAL2_SHIFT_CARRY_EN
    , .shift_carry(carry_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: result, carry and shift amount straight from the operand rules
  function automatic void model(input logic m, input logic i, input logic [31:0] rm,
                                input logic [11:0] so, output logic [31:0] r,
                                output logic c, output int n);
    logic [31:0] x;
    int kind;
    if (m) begin
      x = {{20{so[11]}}, so};
      n = 0;
      kind = 0;
    end else if (i) begin
      x = {24'b0, so[7:0]};
      n = 2 * int'(so[11:8]);
      kind = 3;
    end else begin
      x = rm;
      n = int'(so[11:7]);
      kind = int'(so[6:5]);
    end
    r = x;
    c = 1'b0;
    if (n != 0) begin
      case (kind)
        0: begin r = x << n; c = x[32 - n]; end
        1: begin r = x >> n; c = x[n - 1]; end
        2: begin r = 32'($signed(x) >>> n); c = x[n - 1]; end
        default: begin r = (x >> n) | (x << (32 - n)); c = r[31]; end
      endcase
    end
  endfunction

  task automatic scramble();
    mem_inst      = 1'($urandom);
    imm           = 1'($urandom);
    val_rm        = $urandom;
    shift_operand = 12'($urandom);
  endtask

  task automatic run_txn(input logic m, input logic i, input logic [31:0] rm, input logic [11:0] so);
    logic [31:0] er;
    logic        ec;
    int n, lat_a, lat_b, ba, bb, ov;
    model(m, i, rm, so, er, ec, n);
    @(negedge clk);
    mem_inst = m; imm = i; val_rm = rm; shift_operand = so; start = 1'b1;
    lat_a = 0; lat_b = 0; ba = 0; bb = 0; ov = 0;
    for (int c = 1; c <= 40 && (lat_a == 0 || lat_b == 0); c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      if (busy_a) ba++;
      if (busy_b) bb++;
      if (busy_a && done_a) ov++;
      if (busy_b && done_b) ov++;
      if (done_a && lat_a == 0) begin
        lat_a = c;
        check("val2_s1", val2_a, er);
`ifdef VAL2_SHIFT_CARRY_EN
        check("carry_s1", 32'(carry_a), 32'(ec));
`endif
      end
      if (done_b && lat_b == 0) begin
        lat_b = c;
        check("val2_s4", val2_b, er);
`ifdef VAL2_SHIFT_CARRY_EN
        check("carry_s4", 32'(carry_b), 32'(ec));
`endif
      end
    end
    check("latency_s1", 32'(lat_a), 32'(1 + n));
    check("latency_s4", 32'(lat_b), 32'(1 + (n + 3) / 4));
    check("busy_cycles_s1", 32'(ba), 32'(n));
    check("busy_cycles_s4", 32'(bb), 32'((n + 3) / 4));
    check("done_busy_overlap", 32'(ov), 32'd0);
    check("val2_held_s1", val2_a, er);
    check("val2_held_s4", val2_b, er);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] er, rm0;
    logic        ec;
    int          n, spurious;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_val2_s1", val2_a, 32'd0);
    check("rst_done_s1", 32'(done_a), 32'd0);
    check("rst_busy_s1", 32'(busy_a), 32'd0);
    check("rst_val2_s4", val2_b, 32'd0);
    check("rst_busy_s4", 32'(busy_b), 32'd0);
`ifdef VAL2_SHIFT_CARRY_EN
    check("rst_carry", 32'(carry_a), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    run_txn(1'b0, 1'b1, 32'h0, 12'h4FF);         // imm ROR #8 -> 0xFF000000
    run_txn(1'b0, 1'b0, 32'h80000010, 12'h240);  // ASR #4 -> 0xF8000001
    run_txn(1'b1, 1'b1, 32'h0, 12'hFFC);         // mem offset -> 0xFFFFFFFC
    run_txn(1'b0, 1'b0, 32'h00000003, 12'h0A0);  // LSR #1 -> 1, carry 1
    run_txn(1'b0, 1'b0, 32'h00000003, 12'h000);  // LSL #0, carry 0
    run_txn(1'b0, 1'b0, 32'h80000001, 12'hFE0);  // ROR #31
    run_txn(1'b0, 1'b0, 32'hF0000000, 12'hFC0);  // ASR #31

    // back-to-back: LSR #0, then LSL #1 accepted in the DONE cycle
    @(negedge clk);
    mem_inst = 1'b0; imm = 1'b0; val_rm = 32'h12345678; shift_operand = 12'h020; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_done_s1", 32'(done_a), 32'd1);
    check("b2b_first_val2_s1", val2_a, 32'h12345678);
    check("b2b_first_val2_s4", val2_b, 32'h12345678);
    shift_operand = 12'h080;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_no_gap_busy_s1", 32'(busy_a), 32'd1);
    check("b2b_no_gap_busy_s4", 32'(busy_b), 32'd1);
    @(posedge clk); #1;
    check("b2b_second_done_s1", 32'(done_a), 32'd1);
    check("b2b_second_val2_s1", val2_a, 32'h2468ACF0);
    check("b2b_second_val2_s4", val2_b, 32'h2468ACF0);

    // ROR #31, ignored mid-shift start, reset on the 10th edge
    rm0 = $urandom;
    model(1'b0, 1'b0, rm0, 12'hFE0, er, ec, n);
    spurious = 0;
    @(negedge clk);
    val_rm = rm0; shift_operand = 12'hFE0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c < 10 && done_a) spurious++;
      case (c)
        1: begin start = 1'b0; check("ror31_busy_s1", 32'(busy_a), 32'd1); end
        4: begin start = 1'b1; val_rm = ~rm0; shift_operand = 12'h000; end
        5: start = 1'b0;
        9: begin
          check("ror31_done_s4", 32'(done_b), 32'd1);
          check("ror31_val2_s4", val2_b, er);
          rst = 1'b1;
        end
        default: ;
      endcase
    end
    check("ror31_no_early_done_s1", 32'(spurious), 32'd0);
    check("midrst_val2_s1", val2_a, 32'd0);
    check("midrst_done_s1", 32'(done_a), 32'd0);
    check("midrst_busy_s1", 32'(busy_a), 32'd0);
    check("midrst_val2_s4", val2_b, 32'd0);
    rst = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_a || busy_a || done_b || busy_b) spurious++;
    end
    check("midrst_discarded", 32'(spurious), 32'd0);

    // randomized requests
    for (int t = 0; t < 150; t++) begin
      run_txn(1'(($urandom % 4) == 0), 1'(($urandom % 3) == 0), $urandom, 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
